axi_rd_responder: RTL and testbench
===================================

Name: axi_rd_responder

Overview:
- AXI read-channel responder (subordinate end): accepts AR requests and returns R beats with per-beat address generation for FIXED, INCR and WRAP bursts.
- Flags protocol-illegal requests with SLVERR.
- Serves as the bench/NoC-endpoint counterpart to read initiators.
- Read data is a deterministic function of the beat address, so scoreboards can check every beat without a memory model.

Parameters:
- ID_W, 4, AR/R ID width.
- ADDR_W, 32, address width; must be <= 32.
- DATA_W, 64, R data width; must be a multiple of 32.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ar_id  in  ID_W  request ID.
- ar_addr  in  ADDR_W  start address.
- ar_len  in  8  beats minus one.
- ar_size  in  3  log2 bytes per beat.
- ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 RESERVED.
- ar_valid  in  1  request valid.
- ar_ready  out  1  request accepted this cycle when high together with ar_valid.
- r_id  out  ID_W  echoed ar_id.
- r_data  out  DATA_W  beat data.
- r_resp  out  2  00 OKAY, 10 SLVERR.
- r_last  out  1  final beat.
- r_valid  out  1  beat valid.
- r_ready  in  1  beat accepted.
- busy  out  1  burst in progress.

Behaviour:
- Reset state:
  - Async reset drives state=IDLE and all outputs 0 (ar_ready=0, r_valid=0, r_last=0, r_resp=00, r_id=0, r_data=0, busy=0).
  - ar_ready is registered and rises on the first clk edge after rst_n deasserts.
- FSM, IDLE -> BURST:
  - In IDLE, ar_ready=1.
  - On ar_valid&&ar_ready at edge T: latch id, addr, len, size, burst and error flag.
  - Clear ar_ready; enter BURST.
  - r_valid=1 from T+1 with beat 0. No combinational path AR->R.
- BURST beat handling:
  - On r_valid&&r_ready: advance the beat counter and address.
  - r_last=1 when beat count == len.
  - On the handshake of the last beat: r_valid=0, r_last=0, ar_ready=1, return to IDLE.
  - Minimum gap between bursts is one cycle, so one outstanding request only.
- Stability: r_id, r_data, r_resp and r_last are held stable while r_valid&&!r_ready. r_valid never drops without a handshake.
- Beat address (bytes = 1<<size, aligned = addr & ~(bytes-1)):
  - FIXED: every beat uses addr.
  - INCR: beat 0 uses addr; beat n uses aligned + n*bytes.
  - WRAP: total = bytes*(len+1); lower = addr & ~(total-1); next = cur+bytes; if next == lower+total then next = lower.
  - Address arithmetic is ADDR_W-bit and wraps silently at 2^ADDR_W.
- Data: each 32-bit lane k of r_data = zero-extended beat address XOR k. OKAY beats only; SLVERR beats return r_data=0.
- Error check, evaluated at AR acceptance and applied to all beats (r_resp=SLVERR):
  - burst==RESERVED.
  - size > log2(DATA_W/8).
  - WRAP with len not in {1,3,7,15}.
  - WRAP with addr not aligned to bytes.
  - INCR where aligned + (len+1)*bytes - 1 crosses a 4 KB boundary.
- Error bursts still return exactly len+1 beats with r_last on the final one.
- busy=1 from the AR handshake edge until the last-beat handshake edge.
- Reset mid-burst: outputs return to 0 immediately (async). The partial burst is discarded; no resume.

Optional Feature:
- Macro AXI_RD_RESP_STALL_EN.
- When defined: after every R handshake that is not the last beat, r_valid is forced low for exactly one cycle before the next beat is presented (throttling/back-pressure test mode). Beat content and order are unchanged.
- When undefined: beats stream back-to-back, one per cycle while r_ready=1. The stall logic is removed entirely.

Test Plan:
- INCR, addr=0x100, len=3, size=3, r_ready=1 -> 4 beats on consecutive cycles with beat addresses 0x100, 0x108, 0x110, 0x118; lane0=addr, lane1=addr^1; r_last on beat 3; resp OKAY; r_id echoed.
- WRAP, addr=0x38, len=7, size=3 -> addresses 0x38, 0x00, 0x08, ... 0x30; 8 beats; OKAY.
- WRAP len=2, or INCR addr=0xFF8 len=1 size=3 (crosses 4 KB) -> all beats SLVERR with r_data=0; beat count = len+1; r_last on final beat.
- FIXED, addr=0x44, len=2, with r_ready toggling 1,0,0,1,... -> r_valid stays high and outputs are stable during stalls; 3 beats all with address 0x44.
- Assert rst_n=0 at beat 2 of an 8-beat burst -> r_valid=0 immediately; ar_ready=1 one cycle after release; a new AR is served normally.
- AXI_RD_RESP_STALL_EN defined, INCR len=3, r_ready=1 -> r_valid pattern 1,0,1,0,1,0,1 (7 cycles for 4 beats).

Source files
------------

// File: rtl/axi_rd_responder.sv
// AXI read-channel responder: accepts one AR at a time and streams R beats whose data is derived from the beat address.
// Optional throttling mode: define AXI_RD_RESP_STALL_EN to insert one idle cycle after every non-final R handshake.
module axi_rd_responder #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  input  logic              ar_valid,
  output logic              ar_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              busy
);

  localparam int         LANES      = DATA_W / 32;
  localparam logic [2:0] MAX_SIZE   = 3'($clog2(DATA_W / 8));
  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_BURST    = 1'b1;
  localparam logic [1:0] B_FIXED    = 2'b00;
  localparam logic [1:0] B_INCR     = 2'b01;
  localparam logic [1:0] B_WRAP     = 2'b10;
  localparam logic [1:0] B_RSVD     = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Every 32-bit lane carries the zero-extended beat address XOR its lane index.
  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a);
    logic [31:0]       a32;
    logic [DATA_W-1:0] d;
    a32 = 32'd0;
    a32[ADDR_W-1:0] = a;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      d[k*32 +: 32] = a32 ^ 32'(k);
    end
    return d;
  endfunction

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cur;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_err;

  logic [ADDR_W-1:0] w_ar_bytes;
  logic [ADDR_W-1:0] w_ar_aligned;
  logic [15:0]       w_ar_total;
  logic [32:0]       w_ar_lo33;
  logic [32:0]       w_ar_end33;
  logic              w_ar_len_ok;
  logic              w_ar_err;
  logic              w_ar_hs;

  // Request legality, evaluated on the live AR fields so the flag is latched with the request.
  always_comb begin
    w_ar_bytes   = ADDR_W'(1'b1) << ar_size;
    w_ar_aligned = ar_addr & ~(w_ar_bytes - ADDR_W'(1'b1));
    w_ar_total   = ({8'd0, ar_len} + 16'd1) << ar_size;
    w_ar_lo33    = 33'(w_ar_aligned);
    w_ar_end33   = w_ar_lo33 + {17'd0, w_ar_total} - 33'd1;
    w_ar_len_ok  = (ar_len == 8'd1) || (ar_len == 8'd3) || (ar_len == 8'd7) || (ar_len == 8'd15);
    w_ar_err     = (ar_burst == B_RSVD)
                || (ar_size > MAX_SIZE)
                || ((ar_burst == B_WRAP) && !w_ar_len_ok)
                || ((ar_burst == B_WRAP) && ((ar_addr & (w_ar_bytes - ADDR_W'(1'b1))) != '0))
                || ((ar_burst == B_INCR) && ((w_ar_end33 >> 12) != (w_ar_lo33 >> 12)));
    w_ar_hs      = (r_state == S_IDLE) && ar_valid && ar_ready;
  end

  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_total;
  logic [ADDR_W-1:0] w_lower;
  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_next;

  // Address of the beat following r_cur; the wrap window is anchored to the latched start address.
  always_comb begin
    w_bytes = ADDR_W'(1'b1) << r_size;
    w_total = (ADDR_W'(r_len) + ADDR_W'(1'b1)) << r_size;
    w_lower = r_addr & ~(w_total - ADDR_W'(1'b1));
    w_step  = r_cur + w_bytes;
    case (r_burst)
      B_FIXED: w_next = r_cur;
      B_INCR:  w_next = (r_cur & ~(w_bytes - ADDR_W'(1'b1))) + w_bytes;
      B_WRAP:  w_next = (w_step == (w_lower + w_total)) ? w_lower : w_step;
      default: w_next = r_cur;
    endcase
  end

  // Burst FSM; all R-channel outputs are registered and only change on a handshake or burst start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cur    <= '0;
      r_len    <= 8'd0;
      r_cnt    <= 8'd0;
      r_size   <= 3'd0;
      r_burst  <= 2'b00;
      r_err    <= 1'b0;
      ar_ready <= 1'b0;
      r_id     <= '0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_addr   <= ar_addr;
            r_cur    <= ar_addr;
            r_len    <= ar_len;
            r_cnt    <= 8'd0;
            r_size   <= ar_size;
            r_burst  <= ar_burst;
            r_err    <= w_ar_err;
            r_id     <= ar_id;
            r_data   <= w_ar_err ? '0 : beat_data(ar_addr);
            r_resp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
            r_last   <= (ar_len == 8'd0);
            r_valid  <= 1'b1;
            ar_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_BURST;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        S_BURST: begin
          if (r_valid && r_ready) begin
            if (r_last) begin
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              ar_ready <= 1'b1;
              busy     <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt  <= r_cnt + 8'd1;
              r_cur  <= w_next;
              r_last <= ((r_cnt + 8'd1) == r_len);
              r_data <= r_err ? '0 : beat_data(w_next);
`ifdef AXI_RD_RESP_STALL_EN
              r_valid <= 1'b0;
`endif
            end
          end else begin
`ifdef AXI_RD_RESP_STALL_EN
            r_valid <= 1'b1;
`else
            r_valid <= r_valid;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed vector table, hand-written reset sequence and random bursts
// checked against an address/data model computed directly from the burst rules.
module tb_axi_rd_responder;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              ar_valid;
  logic              ar_ready;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              r_valid;
  logic              r_ready;
  logic              busy;

  axi_rd_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: legality and beat addresses straight from the burst rules.
  function automatic bit m_err(input logic [31:0] a, input int len, input int size, input int burst);
    longint unsigned bytes, aligned, last;
    bytes   = 64'd1 << size;
    aligned = longint'(a) - (longint'(a) % bytes);
    last    = aligned + (len + 1) * bytes - 1;
    if (burst == 3) return 1'b1;
    if (size > 3) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (burst == 2 && (longint'(a) % bytes) != 0) return 1'b1;
    if (burst == 1 && (last / 4096) != (aligned / 4096)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input int len, input int size,
                                         input int burst, input int n);
    longint unsigned bytes, aligned, tot, lower;
    bytes   = 64'd1 << size;
    aligned = longint'(a) - (longint'(a) % bytes);
    tot     = bytes * (len + 1);
    if (burst == 0) return a;
    if (burst == 1) return (n == 0) ? a : 32'(aligned + n * bytes);
    if (burst == 2) begin
      lower = longint'(a) - (longint'(a) % tot);
      return 32'(lower + ((longint'(a) - lower + n * bytes) % tot));
    end
    return a;
  endfunction

  function automatic logic [63:0] m_data(input logic [31:0] a, input bit err);
    return err ? 64'd0 : {a ^ 32'd1, a ^ 32'd0};
  endfunction

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          rmode;      // 0 always ready, 1 pattern 1,0,0,1, 2 random
    bit          exp_err;
    logic [31:0] exp_last;   // hand-derived final-beat address (OKAY vectors only)
  } vec_t;

  // Issue one AR and drain its R beats, checking each beat, stalls, and the return to idle.
  task automatic run_burst(input vec_t v, input bit chk_last);
    int   w, n, cyc, budget, len;
    bit   rdy, held;
    logic [63:0] s_data;
    logic [6:0]  s_ctl;
    logic [31:0] ba;
    len = int'(v.len);
    @(negedge clk);
    ar_id = v.id; ar_addr = v.addr; ar_len = v.len; ar_size = v.size; ar_burst = v.burst;
    ar_valid = 1'b1;
    w = 0;
    while (!ar_ready && w < 20) begin @(negedge clk); w++; end
    if (!ar_ready) begin
      check("ar_ready_timeout", 128'(ar_ready), 128'd1);
      ar_valid = 1'b0;
      return;
    end
    @(negedge clk);
    ar_valid = 1'b0;
    check("ar_ready_drop", {126'd0, ar_ready, busy}, 128'd1);
    n = 0; cyc = 0; held = 1'b0; budget = 5 * (len + 1) + 20;
    s_data = 64'd0; s_ctl = 7'd0;
    while (n <= len && cyc < budget) begin
      case (v.rmode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = ($urandom_range(0, 2) != 0) || (cyc > budget / 2);
      endcase
      if (held) begin
        check("stall_hold", {r_valid, r_id, r_resp, r_last, r_data},
                            {1'b1, s_ctl, s_data});
      end
      if (r_valid) begin
        if (rdy) begin
          ba = m_addr(v.addr, len, int'(v.size), int'(v.burst), n);
          check("beat_data", 128'(r_data), 128'(m_data(ba, v.exp_err)));
          check("beat_ctl", {r_id, r_resp, r_last},
                {v.id, (v.exp_err ? 2'b10 : 2'b00), (n == len)});
          if (chk_last && n == len && !v.exp_err)
            check("last_addr", 128'(r_data[31:0]), 128'(v.exp_last));
          n++;
          held = 1'b0;
        end else begin
          s_data = r_data; s_ctl = {r_id, r_resp, r_last}; held = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
      r_ready = rdy;
      @(negedge clk);
      cyc++;
    end
    r_ready = 1'b0;
    if (n <= len) check("beat_timeout", 128'(n), 128'(len + 1));
    check("idle_after", {125'd0, r_valid, ar_ready, busy}, 128'b010);
    if (v.rmode == 0) begin
`ifdef AXI_RD_RESP_STALL_EN
      check("cycles", 128'(cyc), 128'(2 * len + 1));
`else
      check("cycles", 128'(cyc), 128'(len + 1));
`endif
    end
  endtask

  vec_t vecs[11];
  vec_t rv;

  initial begin
    int w, hs;
    vecs[0]  = '{4'h5, 32'h100, 8'd3, 3'd3, 2'b01, 0, 1'b0, 32'h118};
    vecs[1]  = '{4'h9, 32'h38,  8'd7, 3'd3, 2'b10, 0, 1'b0, 32'h30};
    vecs[2]  = '{4'h2, 32'h40,  8'd2, 3'd3, 2'b10, 0, 1'b1, 32'h0};
    vecs[3]  = '{4'h3, 32'hFF8, 8'd1, 3'd3, 2'b01, 0, 1'b1, 32'h0};
    vecs[4]  = '{4'h6, 32'h44,  8'd2, 3'd2, 2'b00, 1, 1'b0, 32'h44};
    vecs[5]  = '{4'h7, 32'h10,  8'd0, 3'd3, 2'b11, 0, 1'b1, 32'h0};
    vecs[6]  = '{4'h1, 32'h0,   8'd1, 3'd4, 2'b01, 0, 1'b1, 32'h0};
    vecs[7]  = '{4'h4, 32'h3C,  8'd3, 3'd2, 2'b10, 0, 1'b0, 32'h38};
    vecs[8]  = '{4'h8, 32'hFF0, 8'd1, 3'd3, 2'b01, 0, 1'b0, 32'hFF8};
    vecs[9]  = '{4'hA, 32'h0C,  8'd3, 3'd3, 2'b10, 0, 1'b1, 32'h0};
    vecs[10] = '{4'hB, 32'h103, 8'd2, 3'd2, 2'b01, 2, 1'b0, 32'h108};

    rst_n = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = 8'd0; ar_size = 3'd0; ar_burst = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_outs", {r_id, r_data, r_resp, r_last, r_valid, ar_ready, busy}, 128'd0);
    rst_n = 1'b1;
    #1 check("ar_ready_pre", 128'(ar_ready), 128'd0);
    @(negedge clk);
    check("ar_ready_rise", 128'(ar_ready), 128'd1);

    foreach (vecs[i]) run_burst(vecs[i], 1'b1);

    // Reset in the middle of an 8-beat burst, then a fresh request.
    @(negedge clk);
    ar_id = 4'hC; ar_addr = 32'h200; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'b01; ar_valid = 1'b1;
    w = 0;
    while (!ar_ready && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    ar_valid = 1'b0; r_ready = 1'b1; hs = 0; w = 0;
    while (hs < 2 && w < 20) begin
      if (r_valid) hs++;
      @(negedge clk); w++;
    end
    check("pre_reset_busy", {126'd0, r_valid, busy}, 128'b11);
    rst_n = 1'b0;
    #1 check("mid_reset_outs", {r_id, r_data, r_resp, r_last, r_valid, ar_ready, busy}, 128'd0);
    r_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ar_ready_pre", 128'(ar_ready), 128'd0);
    @(negedge clk);
    check("rel_ar_ready", 128'(ar_ready), 128'd1);
    run_burst(vecs[0], 1'b1);

    for (int i = 0; i < 30; i++) begin
      rv.id    = 4'($urandom);
      rv.burst = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      rv.size  = 3'($urandom_range(0, 9) == 0 ? 4 : $urandom_range(0, 3));
      rv.len   = (rv.burst == 2'b10) ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rv.len = 8'($urandom_range(0, 15));
      rv.addr  = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FF80 | 32'($urandom_range(0, 127)))
                                             : 32'($urandom & 32'h0000_3FFF);
      if (rv.burst == 2'b10 && $urandom_range(0, 4) != 0) rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
      rv.rmode   = int'($urandom_range(0, 2));
      rv.exp_err = m_err(rv.addr, int'(rv.len), int'(rv.size), int'(rv.burst));
      rv.exp_last = 32'd0;
      run_burst(rv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
